// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first,
// with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_c;
  logic             br_next_c;
  logic [WIDTH-1:0] sr_shift_c;
  logic             last_c;
  logic             accept_c;

  // Full-subtractor slice on the current LSBs plus the partial result with this bit inserted.
  always_comb begin
    d_c        = sa[0] ^ sb[0] ^ br;
    br_next_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sr_shift_c = {d_c, (WIDTH-1)'(sr >> 1)};
    last_c     = (cnt == CNT_W'(WIDTH - 1));
    accept_c   = ((state == IDLE) || (state == DONE)) && start;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand load, serial shift and result capture on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept_c) begin
      sa  <= a;
      sb  <= b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_shift_c;
      br  <= br_next_c;
      cnt <= cnt + CNT_W'(1);
      if (last_c) begin
        diff <= sr_shift_c;
        bout <= br_next_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done is seen.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_zero = 1'b0;
  exp_t q[$];

  logic [WIDTH-1:0] hold_d = '0;
  logic             hold_b = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: zero checks on request, result hold while busy, scoreboard pop on done.
  always @(negedge clk) begin
    exp_t e;
    if (chk_zero) begin
      chk("zero_diff", int'(diff), 0);
      chk("zero_bout", int'(bout), 0);
      chk("zero_busy", int'(busy), 0);
      chk("zero_done", int'(done), 0);
    end
    if (rst) begin
      hold_d = '0;
      hold_b = 1'b0;
      q.delete();
    end else begin
      if (busy === 1'b1) begin
        chk("hold_diff", int'(diff), int'(hold_d));
        chk("hold_bout", int'(bout), int'(hold_b));
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("bout", int'(bout), int'(e.b));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", int'(busy), 0);
          hold_d = e.d;
          hold_b = e.b;
        end
      end
    end
  end

  // Drive an operation and wait for its acceptance edge; expect done WIDTH cycles later.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] ed, input logic eb);
    exp_t e;
    bit   ok;
    ok    = 1'b0;
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) begin
      $display("FAIL accept_timeout: busy never rose for a=0x%0h b=0x%0h", av, bv);
      $fatal(1);
    end
    e.d   = ed;
    e.b   = eb;
    e.cyc = cyc + WIDTH;
    q.push_back(e);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      $display("FAIL done_timeout: %0d results still pending", q.size());
      $fatal(1);
    end
  endtask

  initial begin
    // Reset for two cycles, then idle for five with all outputs at zero.
    rst = 1'b1;
    @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk_zero = 1'b0;

    // Basic and borrow cases.
    issue(8'h5A, 8'h3C, 8'h1E, 1'b0);
    wait_empty();
    issue(8'h10, 8'h20, 8'hF0, 1'b1);
    wait_empty();
    issue(8'h00, 8'h01, 8'hFF, 1'b1);
    wait_empty();
    issue(8'hFF, 8'hFF, 8'h00, 1'b0);
    wait_empty();

    // start ignored in RUN; operands sampled only at acceptance.
    issue(8'h80, 8'h01, 8'h7F, 1'b0);
    @(posedge clk);
    #1;
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty();
    repeat (12) @(posedge clk);
    #1;

    // Back-to-back: start held into DONE, second done 9 cycles after the first.
    issue(8'h10, 8'h20, 8'hF0, 1'b1);
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    issue(8'h03, 8'h05, 8'hFE, 1'b1);
    wait_empty();
    repeat (3) @(posedge clk);
    #1;

    // Reset four cycles into RUN abandons the operation.
    issue(8'hAA, 8'h11, 8'h99, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    chk_zero = 1'b1;
    @(posedge clk);
    #1 chk_zero = 1'b0;
    issue(8'h64, 8'h32, 8'h32, 1'b0);
    wait_empty();
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
